// File: rtl/board_dump_tx.sv
// board_dump_tx: snapshots the packed 64x4 board on START and streams it as ASCII text over UART 8N1.
// Optional build macro BOARD_DUMP_HEADER_EN prefixes rank digits and appends an "  abcdefgh" footer line.
module board_dump_tx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [255:0] BOARD,
  input  logic         START,
  output logic         TX,
  output logic         BUSY,
  output logic         DONE
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
`ifdef BOARD_DUMP_HEADER_EN
  localparam logic [6:0] NBYTES    = 7'd108;
  localparam logic [3:0] LINE_LAST = 4'd11;
`else
  localparam logic [6:0] NBYTES    = 7'd80;
  localparam logic [3:0] LINE_LAST = 4'd9;
`endif

  if (DIV < 2) begin : g_div_check
    $error("board_dump_tx: CLK_HZ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, LOAD, STARTB, DATA, STOPB, FIN} state_t;

  state_t          state_r, next_s;
  logic [255:0]    snap_r;
  logic [2:0]      row_r, col_r, bit_idx_r, bit_n_s;
  logic [3:0]      lpos_r, nib_s;
  logic [6:0]      byte_cnt_r;
  logic [DW-1:0]   div_cnt_r;
  logic [7:0]      shreg_r, char_s;
  logic            tx_r, busy_r, done_r;
  logic            tick_s, start_ok_s, piece_slot_s;
  logic            tx_d_s, busy_d_s, done_d_s;

  function automatic logic [7:0] piece_char(input logic [3:0] nib);
    logic [7:0] c;
    case (nib[2:0])
      3'd0:    c = 8'h2E;
      3'd1:    c = 8'h70;
      3'd2:    c = 8'h6E;
      3'd3:    c = 8'h62;
      3'd4:    c = 8'h72;
      3'd5:    c = 8'h71;
      3'd6:    c = 8'h6B;
      default: c = 8'h3F;
    endcase
    // '.' and '?' have no case; letters go uppercase by clearing ASCII bit 5
    if (nib[3] && (nib[2:0] != 3'd0) && (nib[2:0] != 3'd7)) begin
      c = c & 8'hDF;
    end else begin
      c = c;
    end
    return c;
  endfunction

  assign tick_s     = (div_cnt_r == DW'(DIV - 1));
  assign start_ok_s = (state_r == IDLE) && START && !busy_r && !done_r;
  assign bit_n_s    = ((state_r == DATA) && tick_s) ? bit_idx_r + 3'd1 : bit_idx_r;
  assign TX   = tx_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

  // Byte selection from the row / column / line-position counters
  always_comb begin
    nib_s        = snap_r[{row_r, col_r, 2'b00} +: 4];
    char_s       = 8'h0A;
    piece_slot_s = 1'b0;
`ifdef BOARD_DUMP_HEADER_EN
    if (byte_cnt_r >= 7'd96) begin
      if (lpos_r < 4'd2) begin
        char_s = 8'h20;
      end else if (lpos_r < 4'd10) begin
        char_s       = 8'h61 + {5'd0, col_r};
        piece_slot_s = 1'b1;
      end else if (lpos_r == 4'd10) begin
        char_s = 8'h0D;
      end else begin
        char_s = 8'h0A;
      end
    end else begin
      if (lpos_r == 4'd0) begin
        char_s = 8'h31 + {5'd0, row_r};
      end else if (lpos_r == 4'd1) begin
        char_s = 8'h20;
      end else if (lpos_r < 4'd10) begin
        char_s       = piece_char(nib_s);
        piece_slot_s = 1'b1;
      end else if (lpos_r == 4'd10) begin
        char_s = 8'h0D;
      end else begin
        char_s = 8'h0A;
      end
    end
`else
    if (lpos_r < 4'd8) begin
      char_s       = piece_char(nib_s);
      piece_slot_s = 1'b1;
    end else if (lpos_r == 4'd8) begin
      char_s = 8'h0D;
    end else begin
      char_s = 8'h0A;
    end
`endif
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; IDLE waits one cycle after the snapshot before LOAD
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (busy_r) next_s = LOAD;
        else        next_s = IDLE;
      end
      LOAD: next_s = STARTB;
      STARTB: begin
        if (tick_s) next_s = DATA;
        else        next_s = STARTB;
      end
      DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) next_s = STOPB;
        else                               next_s = DATA;
      end
      STOPB: begin
        if (!tick_s)                      next_s = STOPB;
        else if (byte_cnt_r == NBYTES)    next_s = FIN;
        else                              next_s = LOAD;
      end
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Output decode, registered below so TX follows the state entered at the same edge
  always_comb begin
    tx_d_s   = 1'b1;
    done_d_s = (state_r == FIN);
    case (next_s)
      STARTB:  tx_d_s = 1'b0;
      DATA:    tx_d_s = shreg_r[bit_n_s];
      default: tx_d_s = 1'b1;
    endcase
    if (start_ok_s) begin
      busy_d_s = 1'b1;
    end else if (state_r == FIN) begin
      busy_d_s = 1'b0;
    end else begin
      busy_d_s = busy_r;
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_d_s;
      busy_r <= busy_d_s;
      done_r <= done_d_s;
    end
  end

  // Snapshot, byte-position counters and bit timing
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      snap_r     <= 256'd0;
      row_r      <= 3'd0;
      col_r      <= 3'd0;
      lpos_r     <= 4'd0;
      byte_cnt_r <= 7'd0;
      div_cnt_r  <= '0;
      bit_idx_r  <= 3'd0;
      shreg_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            snap_r     <= BOARD;
            row_r      <= 3'd7;
            col_r      <= 3'd0;
            lpos_r     <= 4'd0;
            byte_cnt_r <= 7'd0;
          end
        end
        LOAD: begin
          shreg_r    <= char_s;
          byte_cnt_r <= byte_cnt_r + 7'd1;
          div_cnt_r  <= '0;
          bit_idx_r  <= 3'd0;
          if (piece_slot_s) col_r <= col_r + 3'd1;
          if (lpos_r == LINE_LAST) begin
            lpos_r <= 4'd0;
            row_r  <= row_r - 3'd1;
          end else begin
            lpos_r <= lpos_r + 4'd1;
          end
        end
        STARTB, STOPB: begin
          div_cnt_r <= tick_s ? '0 : div_cnt_r + DW'(1);
        end
        DATA: begin
          div_cnt_r <= tick_s ? '0 : div_cnt_r + DW'(1);
          if (tick_s) bit_idx_r <= bit_idx_r + 3'd1;
        end
        default: begin
          div_cnt_r <= div_cnt_r;
        end
      endcase
    end
  end
endmodule

// File: doc/board_dump_tx.md
Name: board_dump_tx

Overview:
- Reads the packed 64x4 board vector, the same one the display reads, and sends it as ASCII over a UART 8N1 serial line.
- Gives a debug/host view of the game state. It is the readout counterpart of the board-change writer path.
- Sits in the top level beside the display interface, in the 25 MHz domain. It is triggered by a one-cycle pulse, e.g. a debounced button.

Parameters:
- CLK_HZ, 25000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate. Bit divisor DIV = CLK_HZ/BAUD, integer floor (217 at defaults). DIV < 2 is a synthesis-time error.

Ports:
- CLK  input  1  system clock, 25 MHz.
- RESET  input  1  asynchronous, active-high reset.
- BOARD  input  256  packed board. Square a occupies [a*4+3:a*4]. a = {row[2:0], col[2:0]}. Bit 3 is colour, bits 2:0 are piece code.
- START  input  1  one-cycle request to dump the board.
- TX  output  1  UART serial out, idle high.
- BUSY  output  1  high while a dump is in progress.
- DONE  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: TX=1, BUSY=0, DONE=0, FSM=IDLE, all counters 0. Reset is asynchronous. Asserting RESET mid-dump aborts it: TX returns high immediately and no DONE pulse is produced.
- Snapshot:
  - When START is sampled high at edge k while in IDLE, BOARD is copied into an internal 256-bit register at edge k.
  - All characters are taken from this copy, so board changes during a dump do not tear the output.
  - BUSY=1 from edge k.
- START is ignored while BUSY=1, including the DONE cycle.
- Character map, piece code to char:
  - 000 '.' (colour ignored), 001 P, 010 N, 011 B, 100 R, 101 Q, 110 K, 111 '?' (colour ignored).
  - Colour bit 1 gives uppercase; colour bit 0 gives lowercase.
- Output order:
  - Row 7 down to row 0. Within a row, col 0 to col 7.
  - Each row is followed by CR (0x0D) then LF (0x0A).
  - Total 80 bytes.
- FSM states: IDLE -> LOAD -> STARTB -> DATA -> STOPB -> (LOAD | FIN) -> IDLE.
  - LOAD: 1 cycle, TX=1. Selects the next byte from the row/col/line-end counters.
  - STARTB: TX=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOPB: TX=1 for DIV cycles.
  - After STOPB, go to LOAD if bytes remain, else FIN.
  - FIN: 1 cycle, DONE=1 and BUSY=0 registered from the FIN edge; then IDLE.
- Timing:
  - First start bit begins at edge k+2 (edge k+1 enters LOAD).
  - Byte period is 10*DIV+1 cycles (2171 at defaults).
  - Total dump time is 80*(10*DIV+1)+2 cycles from the START edge to the DONE edge.
- Counters: the bit-period counter counts 0..DIV-1 and wraps; the bit index is 0..7. Row and col counters decrement and increment respectively, wrapping at 3 bits. Termination uses an explicit byte count, not counter wrap.

Optional Feature:
- Macro: BOARD_DUMP_HEADER_EN.
- Defined:
  - Each row line is prefixed by the rank digit ('8' for row 7 down to '1' for row 0) and a space.
  - After row 0, an extra line "  abcdefgh" CR LF is sent.
  - Total 8*12+12 = 108 bytes; timing formulas use 108 in place of 80.
- Undefined: 80-byte format exactly as above; no header logic is synthesised.

Test Plan:
- Initial-position board, START pulse:
  - Decoded stream is "rnbqkbnr\r\npppppppp\r\n" + 4x"........\r\n" + "PPPPPPPP\r\nRNBQKBNR\r\n".
  - The first byte 'r' = 0x72 appears on TX as bits 0,1,0,0,1,1,1,0, each 217 cycles, after a 217-cycle low start bit.
- Timing: START at edge k.
  - BUSY=1 at k; TX falls at k+2.
  - DONE is high for exactly one cycle at k+2+80*2171.
  - BUSY=0 from that edge.
- Snapshot: modify BOARD square 63 and square 0 to 4'b0110 mid-dump. Output is unchanged. A second dump shows 'k' at line 1 col 8 and 'k' at line 8 col 1.
- START pulses at byte 5 and again in the DONE cycle are both ignored. Exactly 80 bytes and one DONE are produced.
- RESET asserted during the DATA phase of byte 30: TX=1 and BUSY=0 asynchronously, no DONE. A following START produces a full correct 80-byte dump.
- With BOARD_DUMP_HEADER_EN and initial board: stream begins "8 rnbqkbnr\r\n" and ends "1 RNBQKBNR\r\n  abcdefgh\r\n", 108 bytes total.
